fifo_pop_ctrl: RTL

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

---
 rtl/fifo_pop_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_pop_ctrl.sv
// Pop controller for a FIFO with registered read data: decides when to pop,
// carries popped words through a two-stage in-flight pipeline and counts deliveries.
module fifo_pop_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic        fifo_almost_empty,
    input  logic [11:0] fifo_data,
    input  logic        down_full,
    output logic        fifo_rd,
    output logic [11:0] data_out,
    output logic        valid_out,
    output logic [7:0]  pop_count,
    output logic        idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rd_d1_q, rd_d1_d;
    logic        valid_q, valid_d;
    logic [11:0] data_q, data_d;
    logic [7:0]  count_q, count_d;
    logic        fifo_rd_s;

    // Pop strobe: only in ACTIVE, never into an empty FIFO, never against backpressure.
    always_comb begin
        fifo_rd_s = 1'b0;
        if ((state_q == ST_ACTIVE) && enable && !fifo_empty && !down_full) begin
            fifo_rd_s = 1'b1;
        end else begin
            fifo_rd_s = 1'b0;
        end
    end

    // Next-state logic; in ACTIVE a falling enable outranks an emptying FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty && (!fifo_almost_empty || flush)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (fifo_empty) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (!rd_d1_q && !valid_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // In-flight pipeline: the word popped last cycle is on fifo_data while rd_d1 is set.
    always_comb begin
        rd_d1_d = fifo_rd_s;
        valid_d = rd_d1_q;
        data_d  = data_q;
        count_d = count_q;
        if (rd_d1_q) begin
            data_d = fifo_data;
        end else begin
            data_d = data_q;
        end
        if (valid_q) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rd_d1_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 12'h000;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            rd_d1_q <= rd_d1_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Output mapping; idle is decoded purely from registered state.
    always_comb begin
        fifo_rd   = fifo_rd_s;
        data_out  = data_q;
        valid_out = valid_q;
        pop_count = count_q;
        idle      = (state_q == ST_IDLE) && !rd_d1_q && !valid_q;
    end

endmodule
